// File: rtl/qeciphy_rx_boundary_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | qeciphy_rx_boundary_gen: FAW search, bit-slip and frame-lock track  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module qeciphy_rx_boundary_gen #(
  parameter logic [31:0] FAW_WORD       = 32'hBC5C_3C5C,
  parameter int          FRAME_LEN      = 16,
  parameter int          LOCK_COUNT     = 4,
  parameter int          STARTUP_CYCLES = 100,
  parameter int          SLIP_WAIT      = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_enable_i,
  input  logic [31:0] rx_data_i,
  output logic        rx_slip_o,
  output logic        rx_locked_o,
  output logic        faw_err_o,
  output logic [31:0] rx_data_o,
  output logic        rx_valid_o,
  output logic        rx_frame_start_o
);

  localparam int CNT_MAX_A = (STARTUP_CYCLES > SLIP_WAIT) ? STARTUP_CYCLES : SLIP_WAIT;
  localparam int CNT_MAX   = (CNT_MAX_A > FRAME_LEN) ? CNT_MAX_A : FRAME_LEN;
  localparam int CW        = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam int PW        = $clog2(FRAME_LEN);
  localparam int MW        = (LOCK_COUNT > 2) ? $clog2(LOCK_COUNT) : 1;

  localparam logic [CW-1:0] WARM_LAST = CW'(STARTUP_CYCLES - 1);
  localparam logic [CW-1:0] SLIP_LAST = CW'(SLIP_WAIT - 1);
  localparam logic [CW-1:0] MISS_LAST = CW'(FRAME_LEN - 1);
  localparam logic [PW-1:0] POS_LAST  = PW'(FRAME_LEN - 1);
  localparam logic [MW-1:0] HIT_LAST  = MW'(LOCK_COUNT - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WARMUP    = 3'd1;
  localparam logic [2:0] ST_SEARCH    = 3'd2;
  localparam logic [2:0] ST_SLIP_WAIT = 3'd3;
  localparam logic [2:0] ST_VERIFY    = 3'd4;
  localparam logic [2:0] ST_LOCKED    = 3'd5;
  localparam logic [2:0] ST_ERROR     = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [MW-1:0] hits_q, hits_d;
  logic          slip_q, slip_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;
  logic [31:0]   data_q, data_d;
  logic          valid_q, valid_d;
  logic          fs_q, fs_d;

  logic          w_match;
  logic          w_pos0;
  logic [PW-1:0] w_pos_inc;

  assign w_match   = (rx_data_i == FAW_WORD);
  assign w_pos0    = (pos_q == '0);
  assign w_pos_inc = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);

  // pos_q is the frame position of the word sampled on the next edge; the
  // FAW that opens a frame is position 0, so entering VERIFY/LOCKED loads 1.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pos_d    = pos_q;
    hits_d   = hits_q;
    slip_d   = 1'b0;
    locked_d = locked_q;
    err_d    = err_q;
    data_d   = rx_data_i;
    valid_d  = 1'b0;
    fs_d     = 1'b0;

    if (!rx_enable_i) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      pos_d    = '0;
      hits_d   = '0;
      locked_d = 1'b0;
      err_d    = 1'b0;
      data_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_WARMUP;
          cnt_d   = '0;
        end

        ST_WARMUP: begin
          if (cnt_q == WARM_LAST) begin
            state_d = ST_SEARCH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        ST_SEARCH: begin
          if (w_match) begin
            cnt_d  = '0;
            pos_d  = PW'(1);
            hits_d = MW'(1);
            if (LOCK_COUNT <= 1) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
            end else begin
              state_d = ST_VERIFY;
            end
          end else if (cnt_q == MISS_LAST) begin
            state_d = ST_SLIP_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        ST_SLIP_WAIT: begin
          slip_d = (cnt_q == '0);
          if (cnt_q == SLIP_LAST) begin
            state_d = ST_SEARCH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        ST_VERIFY: begin
          pos_d = w_pos_inc;
          if (w_pos0) begin
            if (!w_match) begin
              state_d = ST_SEARCH;
              cnt_d   = '0;
              hits_d  = '0;
            end else if (hits_q == HIT_LAST) begin
              state_d  = ST_LOCKED;
              hits_d   = '0;
              locked_d = 1'b1;
            end else begin
              hits_d = hits_q + MW'(1);
            end
          end
        end

        ST_LOCKED: begin
          pos_d   = w_pos_inc;
          valid_d = 1'b1;
          if (w_pos0) begin
            if (w_match) begin
              fs_d = 1'b1;
            end else begin
              state_d = ST_ERROR;
              err_d   = 1'b1;
              valid_d = 1'b0;
            end
          end
        end

        ST_ERROR: begin
          state_d = ST_ERROR;
        end

        default: begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          pos_d    = '0;
          hits_d   = '0;
          locked_d = 1'b0;
          err_d    = 1'b0;
          data_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pos_q    <= '0;
      hits_q   <= '0;
      slip_q   <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pos_q    <= pos_d;
      hits_q   <= hits_d;
      slip_q   <= slip_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      fs_q     <= fs_d;
    end
  end

  assign rx_slip_o        = slip_q;
  assign rx_locked_o      = locked_q;
  assign faw_err_o        = err_q;
  assign rx_data_o        = data_q;
  assign rx_valid_o       = valid_q;
  assign rx_frame_start_o = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_qeciphy_rx_boundary_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_qeciphy_rx_boundary_gen: directed and random checks vs. a model  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_qeciphy_rx_boundary_gen;

  localparam logic [31:0] FAW     = 32'hBC5C_3C5C;
  localparam int          FL      = 16;
  localparam int          LOCKN   = 4;
  localparam int          STARTUP = 100;
  localparam int          SLIPW   = 32;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        rx_enable_i = 1'b0;
  logic [31:0] rx_data_i = '0;
  logic        rx_slip_o;
  logic        rx_locked_o;
  logic        faw_err_o;
  logic [31:0] rx_data_o;
  logic        rx_valid_o;
  logic        rx_frame_start_o;

  qeciphy_rx_boundary_gen #(
    .FAW_WORD       (FAW),
    .FRAME_LEN      (FL),
    .LOCK_COUNT     (LOCKN),
    .STARTUP_CYCLES (STARTUP),
    .SLIP_WAIT      (SLIPW)
  ) u_dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .rx_enable_i      (rx_enable_i),
    .rx_data_i        (rx_data_i),
    .rx_slip_o        (rx_slip_o),
    .rx_locked_o      (rx_locked_o),
    .faw_err_o        (faw_err_o),
    .rx_data_o        (rx_data_o),
    .rx_valid_o       (rx_valid_o),
    .rx_frame_start_o (rx_frame_start_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: phases tracked by timestamps of edges, not counters.
  typedef enum int {M_IDLE, M_WARM, M_HUNT, M_SLIPW, M_VERIFY, M_LOCKED, M_ERROR} mphase_e;
  mphase_e     m_ph = M_IDLE;
  longint      m_n = 0, m_t0 = 0, m_anchor = 0;
  int          m_hits = 0;
  logic        e_slip = 0, e_locked = 0, e_err = 0, e_valid = 0, e_fs = 0;
  logic [31:0] e_data = '0;

  task automatic model_reset();
    m_ph = M_IDLE; m_hits = 0;
    e_slip = 0; e_locked = 0; e_err = 0; e_valid = 0; e_fs = 0; e_data = '0;
  endtask

  task automatic model_edge(input logic en, input logic [31:0] d);
    logic hit;
    hit = (d == FAW);
    m_n++;
    e_slip = 0; e_valid = 0; e_fs = 0;
    if (!en) begin
      model_reset();
      return;
    end
    e_data = d;
    case (m_ph)
      M_IDLE: begin m_ph = M_WARM; m_t0 = m_n; end
      M_WARM: if (m_n - m_t0 == STARTUP) begin m_ph = M_HUNT; m_t0 = m_n; end
      M_HUNT: begin
        if (hit) begin m_ph = M_VERIFY; m_anchor = m_n; m_hits = 1; end
        else if (m_n - m_t0 == FL) begin m_ph = M_SLIPW; m_t0 = m_n; end
      end
      M_SLIPW: begin
        e_slip = (m_n - m_t0 == 1);
        if (m_n - m_t0 == SLIPW) begin m_ph = M_HUNT; m_t0 = m_n; end
      end
      M_VERIFY: if ((m_n - m_anchor) % FL == 0) begin
        if (hit) begin
          m_hits++;
          if (m_hits == LOCKN) begin m_ph = M_LOCKED; m_anchor = m_n; e_locked = 1; end
        end else begin
          m_ph = M_HUNT; m_t0 = m_n; m_hits = 0;
        end
      end
      M_LOCKED: begin
        if ((m_n - m_anchor) % FL == 0) begin
          if (hit) begin e_valid = 1; e_fs = 1; end
          else begin m_ph = M_ERROR; e_err = 1; end
        end else begin
          e_valid = 1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check("slip",   {31'd0, rx_slip_o},        {31'd0, e_slip});
    check("locked", {31'd0, rx_locked_o},      {31'd0, e_locked});
    check("faw_err",{31'd0, faw_err_o},        {31'd0, e_err});
    check("data",   rx_data_o,                 e_data);
    check("valid",  {31'd0, rx_valid_o},       {31'd0, e_valid});
    check("fstart", {31'd0, rx_frame_start_o}, {31'd0, e_fs});
  endtask

  function automatic logic [31:0] noise();
    logic [31:0] v;
    v = $urandom;
    if (v == FAW) v = ~v;
    return v;
  endfunction

  task automatic step(input logic en, input logic [31:0] d);
    rx_enable_i = en;
    rx_data_i   = d;
    @(posedge clk_i);
    model_edge(en, d);
    #1;
    compare_all();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge arrives.
  task automatic apply_reset();
    #2;
    rst_i = 1'b1;
    rx_enable_i = 1'b0;
    #1;
    model_reset();
    check("rst_slip",   {31'd0, rx_slip_o},        32'd0);
    check("rst_locked", {31'd0, rx_locked_o},      32'd0);
    check("rst_err",    {31'd0, faw_err_o},        32'd0);
    check("rst_data",   rx_data_o,                 32'd0);
    check("rst_valid",  {31'd0, rx_valid_o},       32'd0);
    check("rst_fstart", {31'd0, rx_frame_start_o}, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  // mode 0: clean FAWs, 1: FAW at 165 corrupted, 2: FAW at 117 missing
  task automatic scen_lock(input int mode, input int exp_lock, input int exp_fs, input int exp_err);
    int first_lock, first_fs, first_err, slips;
    logic [31:0] d;
    first_lock = -1; first_fs = -1; first_err = -1; slips = 0;
    step(1'b0, 32'd0);
    for (int k = 0; k < 200; k++) begin
      if (k >= 101 && (k - 101) % FL == 0 && !(mode == 1 && k == 165) && !(mode == 2 && k == 117))
        d = FAW;
      else
        d = noise();
      step(1'b1, d);
      if (rx_locked_o && first_lock < 0) first_lock = k;
      if (rx_frame_start_o && first_fs < 0) first_fs = k;
      if (faw_err_o && first_err < 0) first_err = k;
      if (rx_slip_o) slips++;
    end
    check("dir_lock_cycle", first_lock, exp_lock);
    check("dir_first_fs",   first_fs,   exp_fs);
    check("dir_err_cycle",  first_err,  exp_err);
    check("dir_no_slip",    slips,      0);
  endtask

  task automatic scen_slip();
    int slip_at[$];
    int locks;
    locks = 0;
    step(1'b0, 32'd0);
    for (int k = 0; k < 220; k++) begin
      step(1'b1, noise());
      if (rx_slip_o) slip_at.push_back(k);
      if (rx_locked_o) locks++;
    end
    check("slip_count", slip_at.size(), 3);
    while (slip_at.size() < 3) slip_at.push_back(-1);
    check("slip_0", slip_at[0], 117);
    check("slip_1", slip_at[1], 165);
    check("slip_2", slip_at[2], 213);
    check("slip_nolock", locks, 0);
  endtask

  task automatic random_run(input int ncyc);
    int off;
    logic en;
    logic [31:0] d;
    int r;
    off = $urandom_range(0, FL - 1);
    for (int i = 0; i < ncyc; i++) begin
      r = $urandom_range(0, 999);
      if (r < 2) begin
        apply_reset();
      end else begin
        en = ($urandom_range(0, 399) != 0);
        if (r < 5) off = $urandom_range(0, FL - 1);
        if (((i + off) % FL) == 0 && $urandom_range(0, 49) != 0) d = FAW;
        else if ($urandom_range(0, 99) == 0) d = FAW;
        else d = noise();
        step(en, d);
      end
    end
  endtask

  initial begin
    apply_reset();

    scen_lock(0, 149, 165, -1);
    // reset while locked, then a full restart from WARMUP
    apply_reset();
    scen_lock(0, 149, 165, -1);

    scen_lock(1, 149, -1, 165);
    check("err_valid_low", {31'd0, rx_valid_o},  32'd0);
    check("err_lock_held", {31'd0, rx_locked_o}, 32'd1);
    step(1'b0, noise());
    check("dis_locked", {31'd0, rx_locked_o}, 32'd0);
    check("dis_err",    {31'd0, faw_err_o},   32'd0);
    scen_lock(0, 149, 165, -1);

    scen_lock(2, 181, 197, -1);
    scen_slip();

    for (int run = 0; run < 12; run++) begin
      step(1'b0, 32'd0);
      random_run(700);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
